// File: rtl/pulse_gen_pkg.sv
// pulse_gen_pkg: shared definitions for the pulse generator slice.
//   state_t          - FSM encoding (IDLE, DLY, ACT)
//   RTG_*            - retrigger policy names accepted by pulse_gen.Rtg
//   POL_*            - output polarity names accepted by pulse_gen.Pol
//   inactive_level() - idle level of out for a given polarity
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DLY  = 2'd1,
    ACT  = 2'd2
  } state_t;

  localparam string RTG_IGNORE  = "ignore";
  localparam string RTG_RESTART = "restart";
  localparam string RTG_QUEUE   = "queue";

  localparam string POL_POS = "pos";
  localparam string POL_NEG = "neg";

  // "neg" idles high; everything else idles low.
  function automatic logic inactive_level(input string pol);
    return (pol == POL_NEG) ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/pulse_gen_cnt.sv
// pulse_cnt: loadable down counter with a registered terminal-count flag.
//   clk, rst - clock, asynchronous active-high reset
//   load     - load val (takes priority over en)
//   en       - decrement by one; holds at zero, never wraps
//   val      - load value
//   tc       - high while the count equals 1
module pulse_cnt #(
  parameter int unsigned W_CNT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [W_CNT-1:0] val,
  output logic             tc
);

  logic [W_CNT-1:0] cnt;
  logic [W_CNT-1:0] cnt_dec;

  always_comb begin
    cnt_dec = cnt - W_CNT'(1);
  end

  // tc is computed from the value being written, so it tracks cnt == 1
  // in the same cycle without a comparator on the count output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      tc  <= 1'b0;
    end else if (load) begin
      cnt <= val;
      tc  <= (val == W_CNT'(1));
    end else if (en && (cnt != '0)) begin
      cnt <= cnt_dec;
      tc  <= (cnt_dec == W_CNT'(1));
    end
  end

endmodule

// File: rtl/pulse_gen.sv
// pulse_gen: turns a 1-cycle trigger into an output level that goes active
// after dly cycles and stays active for wid cycles.
//   clk, rst - clock, asynchronous active-high reset
//   trg      - trigger pulse
//   dly, wid - delay / active width in cycles, captured on acceptance
//   out      - shaped output, polarity per Pol
//   bsy      - pulse in delay or active phase
//   done     - 1-cycle strobe after a pulse completes
//   ovf      - sticky lost-trigger flag, cleared by clr_ovf (set wins)
//   clr_ovf  - clears ovf
// Rtg selects what a trigger does while busy: "ignore", "restart", "queue".
module pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int unsigned W_CNT = 16,
  parameter string       Pol   = "pos",
  parameter string       Rtg   = "ignore"
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trg,
  input  logic [W_CNT-1:0] dly,
  input  logic [W_CNT-1:0] wid,
  output logic             out,
  output logic             bsy,
  output logic             done,
  output logic             ovf,
  input  logic             clr_ovf
);

  localparam logic OFF     = inactive_level(Pol);
  localparam logic ON      = ~OFF;
  localparam bit   IGNORE  = (Rtg == RTG_IGNORE);
  localparam bit   RESTART = (Rtg == RTG_RESTART);
  localparam bit   QUEUE   = (Rtg == RTG_QUEUE);

  state_t           state;
  logic [W_CNT-1:0] sh_wid;
  logic             pend;
  logic [W_CNT-1:0] pnd_dly;
  logic [W_CNT-1:0] pnd_wid;

  logic             tc;
  logic             busy;
  logic             at_end;
  logic             fin;
  logic             abort;
  logic             launch;
  logic [W_CNT-1:0] l_dly;
  logic [W_CNT-1:0] l_wid;
  logic             take_pend;
  logic             set_pend;
  logic             lose;
  logic             done_nxt;
  logic             cnt_load;
  logic             cnt_en;
  logic [W_CNT-1:0] cnt_val;

  always_comb begin
    busy      = (state != IDLE);
    at_end    = busy && tc;
    // Completion: end of ACT, or end of DLY when the captured width is zero.
    fin       = at_end && ((state == ACT) || (sh_wid == '0));
    abort     = RESTART && busy && trg;
    launch    = 1'b0;
    l_dly     = dly;
    l_wid     = wid;
    take_pend = 1'b0;
    set_pend  = 1'b0;
    lose      = 1'b0;

    if (!busy) begin
      launch = trg;
    end else if (RESTART) begin
      launch = trg;
    end else if (QUEUE) begin
      take_pend = fin && pend;
      if (take_pend) begin
        launch = 1'b1;
        l_dly  = pnd_dly;
        l_wid  = pnd_wid;
      end else if (trg && fin) begin
        // Empty slot and trigger in the last busy cycle: launch directly,
        // which is exactly what queuing and launching would produce.
        launch = 1'b1;
      end
      if (trg && pend) begin
        lose = 1'b1;
      end else if (trg && !fin) begin
        set_pend = 1'b1;
      end
    end else if (IGNORE) begin
      lose = trg;
    end

    // A zero/zero launch completes immediately and merges with any
    // completion strobe of the pulse it follows.
    done_nxt = (fin && !abort) || (launch && (l_dly == '0) && (l_wid == '0));

    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_val  = '0;
    if (launch) begin
      cnt_load = 1'b1;
      cnt_val  = (l_dly != '0) ? l_dly : l_wid;
    end else if (at_end) begin
      cnt_load = 1'b1;
      cnt_val  = fin ? '0 : sh_wid;
    end else begin
      cnt_en = busy;
    end
  end

  pulse_cnt #(
    .W_CNT (W_CNT)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .en   (cnt_en),
    .val  (cnt_val),
    .tc   (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      out     <= OFF;
      bsy     <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      sh_wid  <= '0;
      pend    <= 1'b0;
      pnd_dly <= '0;
      pnd_wid <= '0;
    end else begin
      done <= done_nxt;
      ovf  <= lose | (ovf & ~clr_ovf);

      if (launch) begin
        sh_wid <= l_wid;
        if (l_dly != '0) begin
          state <= DLY;
          out   <= OFF;
          bsy   <= 1'b1;
        end else if (l_wid != '0) begin
          state <= ACT;
          out   <= ON;
          bsy   <= 1'b1;
        end else begin
          state <= IDLE;
          out   <= OFF;
          bsy   <= 1'b0;
        end
      end else if (fin) begin
        state <= IDLE;
        out   <= OFF;
        bsy   <= 1'b0;
      end else if (at_end) begin
        state <= ACT;
        out   <= ON;
      end

      if (take_pend) begin
        pend <= 1'b0;
      end else if (set_pend) begin
        pend    <= 1'b1;
        pnd_dly <= dly;
        pnd_wid <= wid;
      end
    end
  end

endmodule

// File: tb/tb_pulse_gen.sv
// tb_pulse_gen: directed bench for pulse_gen. Instances:
//   u_ign - pos, ignore      u_rst - pos, restart
//   u_que - pos, queue       u_neg - neg, ignore
//   u_sml - pos, ignore, W_CNT=4 (maximum-count boundary)
// Cycle 0 is the cycle a trigger is driven; outputs are sampled 1 time
// unit after each rising edge.
module tb_pulse_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        trg;
  logic        clr_ovf;
  logic [15:0] dly;
  logic [15:0] wid;
  logic [3:0]  dly4;
  logic [3:0]  wid4;

  logic out_i, bsy_i, done_i, ovf_i;
  logic out_r, bsy_r, done_r, ovf_r;
  logic out_q, bsy_q, done_q, ovf_q;
  logic out_n, bsy_n, done_n, ovf_n;
  logic out_s, bsy_s, done_s, ovf_s;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  pulse_gen #(.W_CNT(16), .Pol("pos"), .Rtg("ignore")) u_ign (
    .clk(clk), .rst(rst), .trg(trg), .dly(dly), .wid(wid),
    .out(out_i), .bsy(bsy_i), .done(done_i), .ovf(ovf_i), .clr_ovf(clr_ovf));

  pulse_gen #(.W_CNT(16), .Pol("pos"), .Rtg("restart")) u_rst (
    .clk(clk), .rst(rst), .trg(trg), .dly(dly), .wid(wid),
    .out(out_r), .bsy(bsy_r), .done(done_r), .ovf(ovf_r), .clr_ovf(clr_ovf));

  pulse_gen #(.W_CNT(16), .Pol("pos"), .Rtg("queue")) u_que (
    .clk(clk), .rst(rst), .trg(trg), .dly(dly), .wid(wid),
    .out(out_q), .bsy(bsy_q), .done(done_q), .ovf(ovf_q), .clr_ovf(clr_ovf));

  pulse_gen #(.W_CNT(16), .Pol("neg"), .Rtg("ignore")) u_neg (
    .clk(clk), .rst(rst), .trg(trg), .dly(dly), .wid(wid),
    .out(out_n), .bsy(bsy_n), .done(done_n), .ovf(ovf_n), .clr_ovf(clr_ovf));

  pulse_gen #(.W_CNT(4), .Pol("pos"), .Rtg("ignore")) u_sml (
    .clk(clk), .rst(rst), .trg(trg), .dly(dly4), .wid(wid4),
    .out(out_s), .bsy(bsy_s), .done(done_s), .ovf(ovf_s), .clr_ovf(clr_ovf));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; trg = 1'b0; clr_ovf = 1'b0;
    dly = '0; wid = '0; dly4 = '0; wid4 = '0;
    tick; tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    do_reset;
    vecs++; if (out_i !== 1'b0) begin errs++; $display("FAIL reset out_pos got=%b exp=0", out_i); end
    vecs++; if (out_n !== 1'b1) begin errs++; $display("FAIL reset out_neg got=%b exp=1", out_n); end
    vecs++; if (bsy_i !== 1'b0) begin errs++; $display("FAIL reset bsy got=%b exp=0", bsy_i); end
    vecs++; if (done_i !== 1'b0) begin errs++; $display("FAIL reset done got=%b exp=0", done_i); end
    vecs++; if (ovf_i !== 1'b0) begin errs++; $display("FAIL reset ovf got=%b exp=0", ovf_i); end
    vecs++; if (out_q !== 1'b0 || bsy_q !== 1'b0) begin errs++; $display("FAIL reset queue out/bsy got=%b%b exp=00", out_q, bsy_q); end
  endtask

  // Single pulse on u_ign; dly/wid are disturbed after acceptance.
  task automatic test_timing(input int d, input int n, input string name);
    logic eo, eb, ed;
    do_reset;
    dly = 16'(d); wid = 16'(n); trg = 1'b1;
    tick;
    trg = 1'b0; dly = 16'd7; wid = 16'd9;
    for (int c = 1; c <= d + n + 3; c++) begin
      eo = (c >= 1 + d) && (c <= d + n);
      eb = (c >= 1) && (c <= d + n);
      ed = (c == d + n + 1);
      vecs++; if (out_i !== eo) begin errs++; $display("FAIL %s out c%0d got=%b exp=%b", name, c, out_i, eo); end
      vecs++; if (bsy_i !== eb) begin errs++; $display("FAIL %s bsy c%0d got=%b exp=%b", name, c, bsy_i, eb); end
      vecs++; if (done_i !== ed) begin errs++; $display("FAIL %s done c%0d got=%b exp=%b", name, c, done_i, ed); end
      tick;
    end
  endtask

  // Trigger in the cycle done is high is accepted; done is not suppressed.
  task automatic test_back_to_back;
    logic eo, ed;
    do_reset;
    dly = 16'd0; wid = 16'd1;
    for (int c = 0; c <= 5; c++) begin
      trg = (c == 0) || (c == 2);
      if (c >= 1) begin
        eo = (c == 1) || (c == 3);
        ed = (c == 2) || (c == 4);
        vecs++; if (out_i !== eo) begin errs++; $display("FAIL b2b out c%0d got=%b exp=%b", c, out_i, eo); end
        vecs++; if (bsy_i !== eo) begin errs++; $display("FAIL b2b bsy c%0d got=%b exp=%b", c, bsy_i, eo); end
        vecs++; if (done_i !== ed) begin errs++; $display("FAIL b2b done c%0d got=%b exp=%b", c, done_i, ed); end
      end
      tick;
    end
    trg = 1'b0;
  endtask

  task automatic test_ignore;
    logic eo, ev, ed;
    do_reset;
    dly = 16'd2; wid = 16'd4;
    for (int c = 0; c <= 13; c++) begin
      trg     = (c == 0) || (c == 3) || (c == 9) || (c == 10) || (c == 11);
      clr_ovf = (c == 8) || (c == 11) || (c == 12);
      if (c >= 1) begin
        eo = ((c >= 3) && (c <= 6)) || (c >= 12);
        ev = ((c >= 4) && (c <= 8)) || (c == 11) || (c == 12);
        ed = (c == 7);
        vecs++; if (out_i !== eo) begin errs++; $display("FAIL ignore out c%0d got=%b exp=%b", c, out_i, eo); end
        vecs++; if (ovf_i !== ev) begin errs++; $display("FAIL ignore ovf c%0d got=%b exp=%b", c, ovf_i, ev); end
        vecs++; if (done_i !== ed) begin errs++; $display("FAIL ignore done c%0d got=%b exp=%b", c, done_i, ed); end
      end
      tick;
    end
    trg = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic test_restart;
    logic eo, eb, ed;
    do_reset;
    for (int c = 0; c <= 11; c++) begin
      trg = (c == 0) || (c == 5);
      if (c == 5) begin dly = 16'd1; wid = 16'd2; end
      else        begin dly = 16'd2; wid = 16'd10; end
      if (c >= 1) begin
        eo = ((c >= 3) && (c <= 5)) || ((c >= 7) && (c <= 8));
        eb = (c >= 1) && (c <= 8);
        ed = (c == 9);
        vecs++; if (out_r !== eo) begin errs++; $display("FAIL restart out c%0d got=%b exp=%b", c, out_r, eo); end
        vecs++; if (bsy_r !== eb) begin errs++; $display("FAIL restart bsy c%0d got=%b exp=%b", c, bsy_r, eb); end
        vecs++; if (done_r !== ed) begin errs++; $display("FAIL restart done c%0d got=%b exp=%b", c, done_r, ed); end
      end
      tick;
    end
    trg = 1'b0;
  endtask

  task automatic test_queue;
    logic eo, eb, ed, ev;
    do_reset;
    for (int c = 0; c <= 9; c++) begin
      trg = (c <= 2);
      case (c)
        0:       begin dly = 16'd1; wid = 16'd2; end
        1:       begin dly = 16'd0; wid = 16'd3; end
        default: begin dly = 16'd5; wid = 16'd5; end
      endcase
      if (c >= 1) begin
        eo = (c >= 2) && (c <= 6);
        eb = (c >= 1) && (c <= 6);
        ed = (c == 4) || (c == 7);
        ev = (c >= 3);
        vecs++; if (out_q !== eo) begin errs++; $display("FAIL queue out c%0d got=%b exp=%b", c, out_q, eo); end
        vecs++; if (bsy_q !== eb) begin errs++; $display("FAIL queue bsy c%0d got=%b exp=%b", c, bsy_q, eb); end
        vecs++; if (done_q !== ed) begin errs++; $display("FAIL queue done c%0d got=%b exp=%b", c, done_q, ed); end
        vecs++; if (ovf_q !== ev) begin errs++; $display("FAIL queue ovf c%0d got=%b exp=%b", c, ovf_q, ev); end
      end
      tick;
    end
    trg = 1'b0;
  endtask

  task automatic test_reset_neg;
    logic eo, eb, ed;
    do_reset;
    dly = 16'd3; wid = 16'd5;
    for (int c = 0; c <= 5; c++) begin
      trg = (c == 0);
      if (c >= 1) begin
        eo = !(c >= 4);
        vecs++; if (out_n !== eo) begin errs++; $display("FAIL neg_pre out c%0d got=%b exp=%b", c, out_n, eo); end
      end
      if (c < 5) tick;
    end
    // Mid-ACT: assert reset between edges and look before the next edge.
    #2 rst = 1'b1;
    #1;
    vecs++; if (out_n !== 1'b1) begin errs++; $display("FAIL neg_rst out got=%b exp=1", out_n); end
    vecs++; if (bsy_n !== 1'b0) begin errs++; $display("FAIL neg_rst bsy got=%b exp=0", bsy_n); end
    vecs++; if (done_n !== 1'b0) begin errs++; $display("FAIL neg_rst done got=%b exp=0", done_n); end
    tick;
    rst = 1'b0;
    for (int c = 0; c <= 11; c++) begin
      trg = (c == 0);
      eo = !((c >= 4) && (c <= 8));
      eb = (c >= 1) && (c <= 8);
      ed = (c == 9);
      vecs++; if (out_n !== eo) begin errs++; $display("FAIL neg_post out c%0d got=%b exp=%b", c, out_n, eo); end
      vecs++; if (bsy_n !== eb) begin errs++; $display("FAIL neg_post bsy c%0d got=%b exp=%b", c, bsy_n, eb); end
      vecs++; if (done_n !== ed) begin errs++; $display("FAIL neg_post done c%0d got=%b exp=%b", c, done_n, ed); end
      tick;
    end
    trg = 1'b0;
  endtask

  // Full-scale delay and width on a 4-bit counter: 15 + 15 cycles.
  task automatic test_max;
    logic eo, eb, ed;
    do_reset;
    dly4 = 4'd15; wid4 = 4'd15; trg = 1'b1;
    tick;
    trg = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      eo = (c >= 16) && (c <= 30);
      eb = (c >= 1) && (c <= 30);
      ed = (c == 31);
      vecs++; if (out_s !== eo) begin errs++; $display("FAIL max out c%0d got=%b exp=%b", c, out_s, eo); end
      vecs++; if (bsy_s !== eb) begin errs++; $display("FAIL max bsy c%0d got=%b exp=%b", c, bsy_s, eb); end
      vecs++; if (done_s !== ed) begin errs++; $display("FAIL max done c%0d got=%b exp=%b", c, done_s, ed); end
      tick;
    end
  endtask

  initial begin
    rst = 1'b1; trg = 1'b0; clr_ovf = 1'b0;
    dly = '0; wid = '0; dly4 = '0; wid4 = '0;
    test_reset;
    test_timing(3, 5, "basic");
    test_timing(0, 1, "d0w1");
    test_timing(0, 0, "d0w0");
    test_timing(2, 0, "d2w0");
    test_back_to_back;
    test_ignore;
    test_restart;
    test_queue;
    test_reset_neg;
    test_max;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
